// File: rtl/ble_uart_pkg.sv
// rtl/ble_uart_pkg.sv - shared 8N1 framing constants and receiver state encoding
package ble_uart_pkg;

   // 8N1 framing shared by receiver and transmitter
   localparam int   UART_DATA_BITS  = 8;
   localparam logic UART_IDLE_LEVEL = 1'b1;

   // Receiver state encoding
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_DATA    = 3'd2,
      ST_STOP    = 3'd3,
      ST_RECOVER = 3'd4
   } uart_state_e;

   // 2-of-3 vote used by the noise-tolerant sampler
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/ble_uart_rx_if.sv
// rtl/ble_uart_rx_if.sv - received-byte stream with valid/ready handshake
interface ble_uart_rx_if;
   import ble_uart_pkg::*;

   logic [UART_DATA_BITS-1:0] tdata;
   logic                      tvalid;
   logic                      tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/ble_uart_rx_obuf.sv
// rtl/ble_uart_rx_obuf.sv - one-byte output holding register with overrun detection
module ble_uart_rx_obuf
   import ble_uart_pkg::*;
(
   input  logic                      clk_in,
   input  logic                      rst_n_in,
   input  logic                      i_push,
   input  logic [UART_DATA_BITS-1:0] i_byte,
   ble_uart_rx_if.master             m_out,
   output logic                      o_overrun
);

   logic [UART_DATA_BITS-1:0] r_data;
   logic                      r_valid;
   logic                      r_overrun;

   // Hold the byte until consumed; a new byte arriving into a full, stalled slot is dropped
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_overrun <= 1'b0;
         if (i_push) begin
            if (r_valid && !m_out.tready) begin
               r_overrun <= 1'b1;
            end else begin
               r_data  <= i_byte;
               r_valid <= 1'b1;
            end
         end else if (r_valid && m_out.tready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign m_out.tdata  = r_data;
   assign m_out.tvalid = r_valid;
   assign o_overrun    = r_overrun;

endmodule

// File: rtl/ble_uart_sync.sv
// rtl/ble_uart_sync.sv - 2-flop synchronizer with parameterized reset value
module ble_uart_sync #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk_in,
   input  logic rst_n_in,
   input  logic i_async,
   output logic o_sync
);

   logic r_meta;
   logic r_sync;

   // Two back-to-back flops; reset to the line's idle level so no false edge appears
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule

// File: rtl/ble_uart_rx.sv
// rtl/ble_uart_rx.sv - oversampled 8N1 UART receiver; BLE_UART_RX_MAJORITY_EN selects 3-sample voting
module ble_uart_rx
   import ble_uart_pkg::*;
#(
   parameter int SAMPLE_RATE = 16
) (
   input  logic                      clk_in,
   input  logic                      rst_n_in,
   input  logic                      tick_in,
   input  logic                      rx_in,
   output logic [UART_DATA_BITS-1:0] data_out,
   output logic                      valid_out,
   input  logic                      ready_in,
   output logic                      framing_err_out,
   output logic                      overrun_out,
   output logic                      busy_out
);

   localparam int            CW   = $clog2(SAMPLE_RATE);
   localparam logic [CW-1:0] HALF = CW'(SAMPLE_RATE / 2);
   localparam logic [CW-1:0] LAST = CW'(SAMPLE_RATE - 1);
   localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);
`ifdef BLE_UART_RX_MAJORITY_EN
   localparam logic [CW-1:0] PRE    = CW'(SAMPLE_RATE / 2 - 1);
   localparam logic [CW-1:0] DECIDE = CW'(SAMPLE_RATE / 2 + 1);
`else
   localparam logic [CW-1:0] DECIDE = HALF;
`endif

   uart_state_e               r_state;
   logic [CW-1:0]             r_cnt;
   logic [2:0]                r_bit;
   logic [UART_DATA_BITS-1:0] r_shift;
   logic                      r_ferr;

   logic w_rx;
   logic w_sample;
   logic w_decide;
   logic w_end;
   logic w_deliver;

   ble_uart_rx_if u_out_if ();

   ble_uart_sync #(
      .RESET_VAL (UART_IDLE_LEVEL)
   ) u_sync (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .i_async  (rx_in),
      .o_sync   (w_rx)
   );

`ifdef BLE_UART_RX_MAJORITY_EN
   logic r_maj_a;
   logic r_maj_b;

   // Capture the two samples just before the decision tick; the third is the live line
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_maj_a <= UART_IDLE_LEVEL;
         r_maj_b <= UART_IDLE_LEVEL;
      end else if (tick_in) begin
         if (r_cnt == PRE)  r_maj_a <= w_rx;
         if (r_cnt == HALF) r_maj_b <= w_rx;
      end
   end

   assign w_sample = maj3(r_maj_a, r_maj_b, w_rx);
`else
   assign w_sample = w_rx;
`endif

   assign w_decide  = (r_cnt == DECIDE);
   assign w_end     = (r_cnt == LAST);
   assign w_deliver = tick_in && (r_state == ST_STOP) && w_decide && w_sample;

   // Frame FSM: counter and bit index move only on oversample ticks
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_ferr  <= 1'b0;
      end else begin
         r_ferr <= 1'b0;
         if (tick_in) begin
            case (r_state)
               ST_IDLE: begin
                  if (!w_rx) begin
                     r_state <= ST_START;
                     r_cnt   <= CW'(1);
                  end
               end
               ST_START: begin
                  // False start takes priority even when the decision lands on the bit end
                  if (w_decide && w_sample) begin
                     r_state <= ST_IDLE;
                     r_cnt   <= '0;
                  end else if (w_end) begin
                     r_state <= ST_DATA;
                     r_cnt   <= '0;
                     r_bit   <= '0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               ST_DATA: begin
                  if (w_decide) r_shift <= {w_sample, r_shift[UART_DATA_BITS-1:1]};
                  if (w_end) begin
                     r_cnt <= '0;
                     if (r_bit == LAST_BIT) r_state <= ST_STOP;
                     else                   r_bit   <= r_bit + 1'b1;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               ST_STOP: begin
                  // Re-arm at mid stop bit so the next start edge is not missed
                  if (w_decide) begin
                     r_cnt <= '0;
                     if (w_sample) begin
                        r_state <= ST_IDLE;
                     end else begin
                        r_state <= ST_RECOVER;
                        r_ferr  <= 1'b1;
                     end
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               ST_RECOVER: begin
                  if (w_rx) r_state <= ST_IDLE;
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
               end
            endcase
         end
      end
   end

   ble_uart_rx_obuf u_obuf (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .i_push    (w_deliver),
      .i_byte    (r_shift),
      .m_out     (u_out_if),
      .o_overrun (overrun_out)
   );

   assign u_out_if.tready = ready_in;
   assign data_out        = u_out_if.tdata;
   assign valid_out       = u_out_if.tvalid;
   assign framing_err_out = r_ferr;
   assign busy_out        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ble_uart_rx.sv
// tb/tb_ble_uart_rx.sv - scoreboard bench for the UART receiver
module tb_ble_uart_rx;

   logic clk_in   = 1'b0;
   logic rst_n_in = 1'b0;
   logic tick_in  = 1'b0;
   logic rx_in    = 1'b1;
   logic ready_in = 1'b0;
   logic framing_err_out;
   logic overrun_out;
   logic busy_out;

   ble_uart_rx_if u_bus ();

   ble_uart_rx #(
      .SAMPLE_RATE (16)
   ) dut (
      .clk_in          (clk_in),
      .rst_n_in        (rst_n_in),
      .tick_in         (tick_in),
      .rx_in           (rx_in),
      .data_out        (u_bus.tdata),
      .valid_out       (u_bus.tvalid),
      .ready_in        (u_bus.tready),
      .framing_err_out (framing_err_out),
      .overrun_out     (overrun_out),
      .busy_out        (busy_out)
   );

   assign u_bus.tready = ready_in;

   int n_checks = 0;
   int n_fail   = 0;
   int n_pres   = 0;
   int n_vcyc   = 0;
   int n_ferr   = 0;
   int n_ovr    = 0;
   logic [7:0] exp_q[$];
   logic pv = 1'b0;
   logic pr = 1'b0;
   int p0, v0, f0, o0;

   always #5 clk_in = ~clk_in;

   // one tick every 4 clocks
   initial begin
      forever begin
         repeat (3) @(negedge clk_in);
         tick_in = 1'b1;
         @(negedge clk_in);
         tick_in = 1'b0;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // monitor: every newly presented byte is popped from the scoreboard
   always @(negedge clk_in) begin
      if (u_bus.tvalid && (!pv || pr)) begin
         n_pres++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_byte: got 0x%0h expected none", u_bus.tdata);
         end else begin
            check("byte", int'(u_bus.tdata), int'(exp_q.pop_front()));
         end
      end
      if (u_bus.tvalid)    n_vcyc++;
      if (framing_err_out) n_ferr++;
      if (overrun_out)     n_ovr++;
      pv = u_bus.tvalid;
      pr = ready_in;
   end

   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         do @(posedge clk_in); while (!tick_in);
      end
      #1;
   endtask

   task automatic drive_bit(input logic v);
      rx_in = v;
      wait_ticks(16);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop);
   endtask

   task automatic snap();
      p0 = n_pres; v0 = n_vcyc; f0 = n_ferr; o0 = n_ovr;
   endtask

   initial begin
      // reset state
      repeat (3) @(posedge clk_in);
      #1;
      check("rst_valid", int'(u_bus.tvalid), 0);
      check("rst_data", int'(u_bus.tdata), 0);
      check("rst_busy", int'(busy_out), 0);
      check("rst_ferr", int'(framing_err_out), 0);
      check("rst_ovr", int'(overrun_out), 0);
      rst_n_in = 1'b1;
      wait_ticks(4);

      // 0x55 with consumer ready
      ready_in = 1'b1;
      snap();
      exp_q.push_back(8'h55);
      send_byte(8'h55, 1'b1);
      wait_ticks(8);
      check("t1_presented", n_pres - p0, 1);
      check("t1_valid_cycles", n_vcyc - v0, 1);
      check("t1_ferr", n_ferr - f0, 0);
      check("t1_ovr", n_ovr - o0, 0);
      check("t1_idle", int'(busy_out), 0);

      // false start: line low for 3 ticks
      snap();
      rx_in = 1'b0;
      wait_ticks(3);
      check("t2_busy", int'(busy_out), 1);
      rx_in = 1'b1;
      wait_ticks(20);
      check("t2_presented", n_pres - p0, 0);
      check("t2_ferr", n_ferr - f0, 0);
      check("t2_idle", int'(busy_out), 0);

      // 0xA3 with stop bit low, then line returns high
      snap();
      send_byte(8'hA3, 1'b0);
      check("t3_recover_busy", int'(busy_out), 1);
      rx_in = 1'b1;
      wait_ticks(4);
      check("t3_ferr_cycles", n_ferr - f0, 1);
      check("t3_presented", n_pres - p0, 0);
      check("t3_idle", int'(busy_out), 0);

      // 0x12 then 0x34 with consumer stalled
      ready_in = 1'b0;
      snap();
      exp_q.push_back(8'h12);
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      wait_ticks(8);
      check("t4_held_data", int'(u_bus.tdata), 8'h12);
      check("t4_presented", n_pres - p0, 1);
      check("t4_ovr_cycles", n_ovr - o0, 1);
      ready_in = 1'b1;
      check("t4_valid_before_accept", int'(u_bus.tvalid), 1);
      @(posedge clk_in);
      #1;
      check("t4_valid_cleared", int'(u_bus.tvalid), 0);

      // reset in the middle of 0xFF while 0x5A is held
      wait_ticks(1);
      ready_in = 1'b0;
      exp_q.push_back(8'h5A);
      send_byte(8'h5A, 1'b1);
      wait_ticks(4);
      check("t5_held_valid", int'(u_bus.tvalid), 1);
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1);
      rx_in = 1'b1;
      wait_ticks(5);
      #2;
      rst_n_in = 1'b0;
      #1;
      check("t5_rst_valid", int'(u_bus.tvalid), 0);
      check("t5_rst_data", int'(u_bus.tdata), 0);
      check("t5_rst_busy", int'(busy_out), 0);
      check("t5_rst_ferr", int'(framing_err_out), 0);
      check("t5_rst_ovr", int'(overrun_out), 0);
      repeat (2) @(negedge clk_in);
      rst_n_in = 1'b1;
      snap();
      wait_ticks(60);
      check("t5_no_ghost_byte", n_pres - p0, 0);
      check("t5_idle", int'(busy_out), 0);
      ready_in = 1'b1;
      exp_q.push_back(8'h0F);
      send_byte(8'h0F, 1'b1);
      wait_ticks(8);
      check("t5_presented", n_pres - p0, 1);
      check("t5_ferr", n_ferr - f0, 0);

      // 0x00 with a one-tick high glitch at each data mid-bit
      snap();
`ifdef BLE_UART_RX_MAJORITY_EN
      exp_q.push_back(8'h00);
`else
      exp_q.push_back(8'hFF);
`endif
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         rx_in = 1'b0;
         wait_ticks(8);
         rx_in = 1'b1;
         wait_ticks(1);
         rx_in = 1'b0;
         wait_ticks(7);
      end
      drive_bit(1'b1);
      wait_ticks(8);
      check("t6_presented", n_pres - p0, 1);
      check("t6_ferr", n_ferr - f0, 0);

      check("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ble_uart_rx.md
BLE_UART_RX -- requirements
Module: ble_uart_rx

Interface
REQ-001 SHALL have parameter SAMPLE_RATE, default 16, meaning tick_in pulses per bit period; legal values are even and >= 4.
REQ-002 SHALL have port clk_in, input, 1, the single system clock; all logic is in this domain.
REQ-003 SHALL have port rst_n_in, input, 1: reset, asynchronous assert, active-low.
REQ-004 SHALL have port tick_in, input, 1: single-cycle oversample strobe, SAMPLE_RATE per bit.
REQ-005 SHALL have port rx_in, input, 1: asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port data_out, output, 8: received byte, stable while valid_out=1.
REQ-007 SHALL have port valid_out, output, 1: data_out holds an unconsumed byte.
REQ-008 SHALL have port ready_in, input, 1: consumer accepts; transfer when valid_out && ready_in.
REQ-009 SHALL have port framing_err_out, output, 1: one-cycle pulse on stop bit sampled low.
REQ-010 SHALL have port overrun_out, output, 1: one-cycle pulse when a byte is dropped.
REQ-011 SHALL have port busy_out, output, 1: high in any state other than IDLE.

Function
REQ-012 SHALL pass rx_in through a 2-flop synchronizer (flops reset to 1) before any use; all "rx" below means the synchronized value.
REQ-013 SHALL implement states IDLE, START, DATA, STOP, RECOVER; counter and bit index advance only on tick_in.
REQ-014 IDLE: on a tick with rx=0, SHALL go to START with counter=1; otherwise stay.
REQ-015 Mid-bit sample point SHALL be counter==SAMPLE_RATE/2; bit end SHALL be counter==SAMPLE_RATE-1, after which counter wraps to 0.
REQ-016 START: mid-bit sample of 1 SHALL be a false start -> IDLE, no outputs; sample of 0 SHALL proceed to DATA at bit end.
REQ-017 DATA: SHALL shift in 8 mid-bit samples LSB first, then enter STOP at the 8th bit end.
REQ-018 STOP: at mid-bit, sample 1 SHALL deliver the byte and go to IDLE immediately (re-arm half a bit early); sample 0 SHALL pulse framing_err_out, discard the byte, and go to RECOVER.
REQ-019 RECOVER: SHALL return to IDLE on the first tick with rx=1.
REQ-020 Delivery SHALL occur on the cycle after the stop sample: data_out loaded, valid_out=1.
REQ-021 valid_out SHALL stay 1 and data_out unchanged until a cycle with ready_in=1; valid_out then clears next cycle.
REQ-022 If delivery coincides with valid_out=1 and ready_in=0, SHALL keep the old byte, drop the new one, and pulse overrun_out.
REQ-023 If delivery coincides with valid_out=1 and ready_in=1, SHALL load the new byte with valid_out remaining 1, no overrun.
REQ-024 tick_in SHALL be ignored while no state change is due; ready_in while valid_out=0 has no effect.

Reset
REQ-025 On rst_n_in low, SHALL immediately force: state IDLE, counter 0, bit index 0, shift register 0, synchronizer 1, data_out 0x00, valid_out 0, framing_err_out 0, overrun_out 0, busy_out 0.
REQ-026 Reset mid-byte SHALL discard the partial byte; after release a new start bit is required.

Configuration
REQ-027 Macro BLE_UART_RX_MAJORITY_EN defined: each START/DATA/STOP sample SHALL be the 2-of-3 majority of rx at counters SAMPLE_RATE/2-1, SAMPLE_RATE/2, SAMPLE_RATE/2+1, decided at SAMPLE_RATE/2+1.
REQ-028 Macro undefined: SHALL use the single sample at counter SAMPLE_RATE/2; no majority logic synthesized.

Structure
REQ-029 SHALL take the shared state enum and 8N1 framing constants (data bits=8, idle level=1) from package ble_uart_pkg, shared with the transmitter.
REQ-030 SHALL instantiate sub-module ble_uart_sync (2-flop synchronizer, reset value parameterized) for rx_in.

Verification
REQ-031 Byte 0x55 at 16 ticks/bit, ready_in=1 -> one valid_out cycle with data_out=0x55, no errors.
REQ-032 rx_in low for 3 ticks then high -> returns to IDLE, no valid_out, no framing_err_out.
REQ-033 Byte 0xA3 with stop bit 0, then line high -> framing_err_out single pulse, no valid_out, IDLE after line high.
REQ-034 Bytes 0x12 then 0x34 back-to-back, ready_in=0 -> data_out=0x12 held, overrun_out one pulse; ready_in=1 afterwards -> valid_out clears.
REQ-035 rst_n_in asserted at bit 4 of 0xFF -> all outputs at reset values at once; next clean 0x0F received correctly.
REQ-036 With BLE_UART_RX_MAJORITY_EN, 0x00 with one-tick high glitch at each mid-bit -> data_out=0x00; without macro -> data_out=0xFF.
